// File: rtl/adc_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_trigger_capture
// Brief    : Level-crossing trigger with pre-trigger circular capture buffer.
//            Streams one N-sample frame per event as a contiguous burst.
// Revision : 1.0 - initial release
// ============================================================================
module adc_trigger_capture #(
  parameter int DW      = 10,
  parameter int N       = 256,
  parameter int PRE     = 64,
  parameter int AUTO_TO = 4096,
  parameter int HOLDOFF = 1024
) (
  input  logic          clkADC,
  input  logic          n_reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic [DW-1:0] level,
  input  logic          falling,
  input  logic          auto_mode,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_start,
  output logic          triggered,
  output logic          busy
);

  localparam int AW       = $clog2(N);
  localparam int RW       = AW + 1;
  localparam int FW       = $clog2(PRE + 1);
  localparam int TW       = $clog2(AUTO_TO + 1);
  localparam int HW       = $clog2(HOLDOFF + 1);
  localparam int POST_LEN = N - PRE - 1;

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_ARM  = 3'd1,
    S_POST = 3'd2,
    S_READ = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [TW-1:0] auto_cnt_q, auto_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [RW-1:0] rd_cnt_q, rd_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q, out_valid_d;
  logic          out_start_q, out_start_d;
  logic          trig_q, trig_d;

  logic [DW-1:0] mem_q [N];

  logic accept;
  logic edge_hit;
  logic auto_hit;

  // Samples are only stored while building a frame; READ and HOLD drop them.
  assign accept = in_valid &&
                  (state_q == S_FILL || state_q == S_ARM || state_q == S_POST);

  // Crossing test against the live threshold; equality on both sides never fires.
  assign edge_hit = falling ? ((prev_q > level) && (in_data <= level))
                            : ((prev_q < level) && (in_data >= level));
  assign auto_hit = auto_mode && (auto_cnt_q == TW'(AUTO_TO - 1));

  // Capture RAM write port; no reset so it maps onto block RAM.
  always_ff @(posedge clkADC) begin
    if (accept) mem_q[wp_q] <= in_data;
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    prev_d      = prev_q;
    fill_cnt_d  = fill_cnt_q;
    auto_cnt_d  = auto_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    trig_d      = 1'b0;

    if (accept) begin
      wp_d   = wp_q + AW'(1);
      prev_d = in_data;
    end

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (fill_cnt_q == FW'(PRE - 1)) begin
            state_d    = S_ARM;
            auto_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FW'(1);
          end
        end
      end
      S_ARM: begin
        if (accept) begin
          if (auto_mode) auto_cnt_d = auto_cnt_q + TW'(1);
          if (edge_hit || auto_hit) begin
            // The trigger sample sits at wp; the frame starts PRE before it.
            trig_d     = edge_hit;
            rp_d       = wp_q - AW'(PRE);
            post_cnt_d = '0;
            rd_cnt_d   = '0;
            state_d    = (POST_LEN == 0) ? S_READ : S_POST;
          end
        end
      end
      S_POST: begin
        if (accept) begin
          if (post_cnt_q == AW'(POST_LEN - 1)) state_d = S_READ;
          else                                 post_cnt_d = post_cnt_q + AW'(1);
        end
      end
      S_READ: begin
        // Issue one RAM read per cycle; data appears one cycle later.
        if (!rd_cnt_q[AW]) begin
          out_valid_d = 1'b1;
          out_start_d = (rd_cnt_q == '0);
          rd_cnt_d    = rd_cnt_q + RW'(1);
          rp_d        = rp_q + AW'(1);
        end else begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HW'(HOLDOFF - 1)) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge clkADC or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_FILL;
      wp_q       <= '0;
      rp_q       <= '0;
      prev_q     <= '0;
      fill_cnt_q <= '0;
      auto_cnt_q <= '0;
      post_cnt_q <= '0;
      rd_cnt_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      prev_q     <= prev_d;
      fill_cnt_q <= fill_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      post_cnt_q <= post_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Registered output stage, including the synchronous RAM read.
  always_ff @(posedge clkADC or negedge n_reset) begin
    if (!n_reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      if (out_valid_d) out_data_q <= mem_q[rp_q];
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      trig_q      <= trig_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign triggered = trig_q;
  assign busy      = (state_q == S_POST) || (state_q == S_READ);

endmodule
`default_nettype wire

// File: tb/tb_adc_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_trigger_capture
// Brief    : Self-checking bench for adc_trigger_capture (N=16, PRE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_trigger_capture;

  localparam int DW = 10;
  localparam int N  = 16;

  logic          clkADC = 1'b0;
  logic          n_reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] level;
  logic          falling;
  logic          auto_mode;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_start;
  logic          triggered;
  logic          busy;

  adc_trigger_capture #(
    .DW(DW), .N(N), .PRE(4), .AUTO_TO(32), .HOLDOFF(8)
  ) dut (
    .clkADC(clkADC), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
    .level(level), .falling(falling), .auto_mode(auto_mode),
    .out_data(out_data), .out_valid(out_valid), .out_start(out_start),
    .triggered(triggered), .busy(busy)
  );

  always #5 clkADC = ~clkADC;

  typedef struct {
    int kind;      // 0 ramp, 1 step-down, 2 const 5, 3 ramp+gaps, 4 ramp, 5 ramp auto-pause, 6 ramp, 7 const 60
    int lvl;
    bit fall;
    bit autom;
    bit gaps;
    int base;
    bit ramp;
    int exp_trig;
  } vec_t;

  vec_t          tbl [8];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] expv;
  int            total = 0;
  int            bad   = 0;
  int            run_len = 0;
  int            trig_cnt = 0;
  bit            burst_done = 0;
  bit            mon_en = 1;

  function automatic logic [DW-1:0] stim_val(input int kind, input int i);
    case (kind)
      1:       return (i < 10) ? 10'd100 : 10'd50;
      2:       return 10'd5;
      7:       return 10'd60;
      default: return 10'(i);
    endcase
  endfunction

  function automatic logic stim_auto(input vec_t v, input int i);
    if (v.kind == 5 && i >= 10 && i <= 19) return 1'b0;
    return v.autom;
  endfunction

  function automatic logic [DW-1:0] exp_val(input vec_t v, input int k);
    if (v.kind == 1) return (k < 4) ? 10'd100 : 10'd50;
    if (v.ramp)      return 10'(v.base + k);
    return 10'(v.base);
  endfunction

  // Scoreboard: every burst sample is popped and compared; run length checked at burst end.
  always @(negedge clkADC) begin
    if (mon_en) begin
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: out_valid=1 out_data=%0d, required out_valid=0", out_data);
        end else begin
          expv = exp_q.pop_front();
          if (out_data !== expv) begin
            bad++;
            $display("FAIL burst_data[%0d]: got %0d required %0d", run_len, out_data, expv);
          end
        end
        total++;
        if (out_start !== (run_len == 0)) begin
          bad++;
          $display("FAIL out_start[%0d]: got %0b required %0b", run_len, out_start, (run_len == 0));
        end
        run_len++;
      end else begin
        if (out_start) begin
          total++;
          bad++;
          $display("FAIL start_without_valid: out_start=1 required 0");
        end
        if (run_len != 0) begin
          total++;
          if (run_len != N) begin
            bad++;
            $display("FAIL burst_len: got %0d required %0d", run_len, N);
          end
          run_len    = 0;
          burst_done = 1;
        end
      end
      if (triggered) trig_cnt++;
    end
  end

  task automatic apply_reset();
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    auto_mode = 1'b0;
    exp_q.delete();
    run_len    = 0;
    burst_done = 0;
    trig_cnt   = 0;
    repeat (2) @(posedge clkADC);
    @(negedge clkADC);
    n_reset = 1'b1;
    @(posedge clkADC);
    #1;
  endtask

  task automatic check_end(input string name, input int etrig);
    total++;
    if (!burst_done) begin
      bad++;
      $display("FAIL %s_timeout: burst_done=0 required 1", name);
    end
    total++;
    if (trig_cnt != etrig) begin
      bad++;
      $display("FAIL %s_triggered: got %0d pulses required %0d", name, trig_cnt, etrig);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: got %0d unread samples required 0", name, exp_q.size());
    end
  endtask

  task automatic run_vec(input vec_t v, input bit do_rst);
    int i;
    int cyc;
    if (do_rst) apply_reset();
    trig_cnt   = 0;
    burst_done = 0;
    for (int k = 0; k < N; k++) exp_q.push_back(exp_val(v, k));
    level   = 10'(v.lvl);
    falling = v.fall;
    i   = 0;
    cyc = 0;
    while (!burst_done && cyc < 3000) begin
      in_valid  = v.gaps ? ~cyc[0] : 1'b1;
      in_data   = stim_val(v.kind, i);
      auto_mode = stim_auto(v, i);
      if (in_valid) i++;
      cyc++;
      @(posedge clkADC);
      #1;
    end
    check_end($sformatf("vec%0d", v.kind), v.exp_trig);
  endtask

  // Rising-edge ramp starting at 'start'; first drive happens immediately.
  task automatic run_ramp(input string name, input int start, input int lvl,
                          input int base, input int etrig);
    int j;
    int cyc;
    trig_cnt   = 0;
    burst_done = 0;
    level      = 10'(lvl);
    falling    = 1'b0;
    auto_mode  = 1'b0;
    for (int k = 0; k < N; k++) exp_q.push_back(10'(base + k));
    j   = start;
    cyc = 0;
    while (!burst_done && cyc < 2000) begin
      in_data  = 10'(j);
      in_valid = 1'b1;
      j++;
      cyc++;
      @(posedge clkADC);
      #1;
    end
    check_end(name, etrig);
  endtask

  initial begin
    int cnt;
    int cyc;
    int ov;
    tbl[0] = '{0,   20, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1};
    tbl[1] = '{1,   60, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1};
    tbl[2] = '{2,  500, 1'b0, 1'b1, 1'b0,  5, 1'b0, 0};
    tbl[3] = '{3,   17, 1'b0, 1'b0, 1'b1, 13, 1'b1, 1};
    tbl[4] = '{4, 1000, 1'b0, 1'b1, 1'b0, 31, 1'b1, 0};
    tbl[5] = '{5, 1000, 1'b0, 1'b1, 1'b0, 41, 1'b1, 0};
    tbl[6] = '{6,   35, 1'b0, 1'b1, 1'b0, 31, 1'b1, 1};
    tbl[7] = '{7,   60, 1'b0, 1'b1, 1'b0, 60, 1'b0, 0};

    level   = '0;
    falling = 1'b0;
    apply_reset();

    // Reset state.
    total++; if (out_data  !== '0)   begin bad++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    total++; if (out_start !== 1'b0) begin bad++; $display("FAIL rst_out_start: got %0b required 0", out_start); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rst_triggered: got %0b required 0", triggered); end
    total++; if (busy      !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b required 0", busy); end

    for (int t = 0; t < 8; t++) run_vec(tbl[t], 1'b1);

    // Holdoff: samples arriving during the 8 HOLD cycles are dropped; the
    // first kept sample is 7, so level 11 only fires if FILL starts on time.
    run_vec(tbl[0], 1'b1);
    run_ramp("holdoff", 0, 11, 7, 1);

    // Normal mode: no forced capture, then a real crossing.
    apply_reset();
    level     = 10'd500;
    falling   = 1'b0;
    auto_mode = 1'b0;
    ov = 0;
    for (int c = 0; c < 500; c++) begin
      in_data  = 10'd5;
      in_valid = 1'b1;
      @(negedge clkADC);
      if (out_valid) ov++;
      @(posedge clkADC);
      #1;
    end
    total++;
    if (ov != 0) begin bad++; $display("FAIL normal_idle: got %0d out_valid cycles required 0", ov); end
    run_ramp("normal", 480, 500, 496, 1);

    // Reset on the 5th burst output.
    apply_reset();
    mon_en  = 0;
    level   = 10'd20;
    falling = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 5 && cyc < 500) begin
      in_data  = 10'(cyc);
      in_valid = 1'b1;
      cyc++;
      @(negedge clkADC);
      if (out_valid) cnt++;
      if (cnt < 5) begin
        @(posedge clkADC);
        #1;
      end
    end
    total++;
    if (cnt != 5) begin bad++; $display("FAIL rstmid_timeout: got %0d outputs required 5", cnt); end
    n_reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %0b required 0", out_valid); end
    total++; if (out_start !== 1'b0) begin bad++; $display("FAIL rstmid_out_start: got %0b required 0", out_start); end
    total++; if (out_data  !== '0)   begin bad++; $display("FAIL rstmid_out_data: got %0d required 0", out_data); end
    total++; if (busy      !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rstmid_triggered: got %0b required 0", triggered); end
    in_valid = 1'b0;
    repeat (2) @(posedge clkADC);
    @(negedge clkADC);
    n_reset    = 1'b1;
    run_len    = 0;
    burst_done = 0;
    trig_cnt   = 0;
    exp_q.delete();
    mon_en     = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkADC);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_residual[%0d]: out_valid=%0b busy=%0b required 0 0", c, out_valid, busy);
      end
    end
    @(posedge clkADC);
    #1;
    run_vec(tbl[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
- Sits between the ADC sampler and the waveform display in the clkADC domain.
- Watches the continuous ADC sample stream for a level crossing and captures one frame of N samples around that event, with PRE samples before the trigger, into a circular buffer.
- Streams the frame out as a contiguous burst with a start marker, which the display stage writes into the frame buffer.
- Auto mode forces a capture when no trigger occurs, so the screen never freezes.

Parameters:
- DW, 10, sample width in bits.
- N, 256, frame length in samples; must be a power of 2.
- PRE, 64, pre-trigger samples kept; 1 <= PRE < N.
- AUTO_TO, 4096, accepted samples without a trigger before auto mode forces one.
- HOLDOFF, 1024, clock cycles idle after readout before re-arming.

Ports:
- clkADC  in  1  block clock; all logic on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- in_data  in  DW  ADC sample, unsigned.
- in_valid  in  1  in_data is a new sample this cycle.
- level  in  DW  trigger threshold, unsigned.
- falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- auto_mode  in  1  1 = force a trigger after AUTO_TO samples.
- out_data  out  DW  frame sample.
- out_valid  out  1  out_data is valid.
- out_start  out  1  marks the first sample of a frame; only ever high together with out_valid.
- triggered  out  1  high for 1 cycle when a real (non-forced) trigger is accepted.
- busy  out  1  high in the POST and READ states.

Behaviour:
- Reset (asynchronous, n_reset=0):
  - state=FILL, all counters and pointers = 0, stored prev sample = 0.
  - out_data=0, out_valid=0, out_start=0, triggered=0, busy=0.
  - Asserting reset mid-frame aborts the frame immediately. No partial burst continues after reset is released.
- Buffer and sampling:
  - N x DW circular RAM with write pointer wp (log2 N bits, wraps N-1 -> 0).
  - In FILL, ARM and POST, each in_valid writes in_data at wp, then wp++.
  - Samples arriving in READ or HOLD are dropped.
- Trigger condition, evaluated only on an in_valid cycle in ARM, with prev = last accepted sample:
  - rising: prev < level && in_data >= level.
  - falling: prev > level && in_data <= level.
  - prev updates on every accepted sample in any state; it is not cleared between frames.
  - level and falling are sampled each cycle; they are not latched.
- FILL:
  - Counts accepted samples.
  - Moves to ARM when the count reaches PRE, i.e. after the PRE-th write.
  - Triggers are ignored in FILL.
- ARM:
  - On a trigger: taddr = wp (the address of the triggering sample), pulse triggered, go to POST.
  - Auto: if auto_mode=1 and AUTO_TO accepted samples pass in ARM without a trigger, force a trigger on the AUTO_TO-th sample. taddr is its address; triggered is NOT pulsed.
  - The auto counter clears on entry to ARM.
  - If auto_mode drops mid-count, the counter holds; it resumes when auto_mode rises again.
- POST:
  - Writes N-PRE-1 further samples after the triggering one, then goes to READ.
  - The frame therefore holds PRE samples before the trigger, the trigger sample, and N-PRE-1 samples after it.
- READ:
  - Read pointer starts at rp = taddr - PRE, modulo N.
  - out_valid is high for exactly N consecutive cycles; out_data = RAM[rp], rp++.
  - out_start is high on the first of those cycles only.
  - First out_valid appears at most 2 cycles after entering READ, to allow for RAM read latency.
  - There is no backpressure; the consumer must accept 1 sample per cycle.
  - Goes to HOLD after the N-th output.
- HOLD:
  - Waits HOLDOFF cycles, then enters FILL with the fill count cleared.
  - wp continues from its current value.
- busy = 1 in POST and READ.
- Simultaneous events: a trigger and auto timeout on the same sample count as a real trigger, so triggered pulses.
- Equal samples (prev == level == in_data) never trigger.

Test Plan (N=16, PRE=4, AUTO_TO=32, HOLDOFF=8, DW=10, in_valid=1 every cycle unless stated):
- Ramp in_data = 0,1,2,...; level=20; rising -> triggered pulses once, on sample 20. Burst of 16 outputs = 16..31 with out_start on 16. Then HOLD for 8 cycles, then FILL.
- Falling edge: in_data = 100 for 10 samples, then 50; level=60; falling=1 -> trigger on the 50 sample. Burst = 4 x 100, 50, then 11 x 50.
- Auto: constant in_data=5, level=500, auto_mode=1 -> forced trigger on the 32nd sample in ARM. triggered stays 0. Burst of 16 samples all = 5.
- Normal mode: same as the auto case with auto_mode=0 -> no out_valid for 500 cycles, then a ramp crossing level -> normal capture.
- Wrap plus gaps: in_valid toggles 1/0 and the trigger is placed so that taddr-PRE wraps below 0 -> burst order is still the chronological sample sequence. The out_valid burst is contiguous for 16 cycles.
- Assert n_reset=0 on the 5th READ output -> all outputs 0 within the same cycle. After release: state FILL and no residual out_valid; the next frame is correct.
